// File: rtl/alu_arbiter.sv
// Round-robin front end that shares one external combinational ALU between two
// requesters; each accepted op runs for one cycle and lands in that port's response slot.
module alu_arbiter (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid_0,
    input  logic        req_valid_1,
    output logic        req_ready_0,
    output logic        req_ready_1,
    input  logic [31:0] req_a_0,
    input  logic [31:0] req_a_1,
    input  logic [31:0] req_b_0,
    input  logic [31:0] req_b_1,
    input  logic [3:0]  req_ctrl_0,
    input  logic [3:0]  req_ctrl_1,
    output logic        resp_valid_0,
    output logic        resp_valid_1,
    input  logic        resp_ready_0,
    input  logic        resp_ready_1,
    output logic [31:0] resp_result_0,
    output logic [31:0] resp_result_1,
    output logic        resp_zero_0,
    output logic        resp_zero_1,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [3:0]  alu_ctrl,
    input  logic [31:0] alu_result,
    input  logic        alu_zero,
    output logic        busy
);

    typedef enum logic {IDLE = 1'b0, EXEC = 1'b1} state_t;

    localparam logic [3:0] NOP_CTRL = 4'b1111;

    state_t      state_reg, state_next;
    logic        last_grant_reg;
    logic        owner_reg;
    logic [31:0] op_a_reg, op_b_reg;
    logic [3:0]  op_ctrl_reg;

    logic [1:0]  resp_valid_reg;
    logic [31:0] resp_result_reg [2];
    logic [1:0]  resp_zero_reg;
    logic [1:0]  resp_ready_vec;

    logic        elig_0, elig_1;
    logic        grant_any;
    logic        grant;
    logic        accept;
    logic        finish;

    // A port with an unconsumed response may not issue again.
    assign elig_0    = req_valid_0 & ~resp_valid_reg[0];
    assign elig_1    = req_valid_1 & ~resp_valid_reg[1];
    assign grant_any = elig_0 | elig_1;
    assign grant     = (elig_0 & elig_1) ? ~last_grant_reg : elig_1;
    assign accept    = (state_reg == IDLE) & grant_any;
    assign finish    = (state_reg == EXEC);

    assign resp_ready_vec = {resp_ready_1, resp_ready_0};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: if (accept) state_next = EXEC;
            EXEC: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        req_ready_0 = 1'b0;
        req_ready_1 = 1'b0;
        busy        = 1'b0;
        alu_a       = 32'd0;
        alu_b       = 32'd0;
        alu_ctrl    = NOP_CTRL;
        case (state_reg)
            IDLE: begin
                req_ready_0 = grant_any & ~grant;
                req_ready_1 = grant_any & grant;
            end
            EXEC: begin
                busy     = 1'b1;
                alu_a    = op_a_reg;
                alu_b    = op_b_reg;
                alu_ctrl = op_ctrl_reg;
            end
            default: ;
        endcase
    end

    // Operands are sampled only on the handshake; withdrawn requests leave no trace.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            owner_reg      <= 1'b0;
            last_grant_reg <= 1'b1;
            op_a_reg       <= 32'd0;
            op_b_reg       <= 32'd0;
            op_ctrl_reg    <= 4'd0;
        end else begin
            if (accept) begin
                owner_reg   <= grant;
                op_a_reg    <= grant ? req_a_1 : req_a_0;
                op_b_reg    <= grant ? req_b_1 : req_b_0;
                op_ctrl_reg <= grant ? req_ctrl_1 : req_ctrl_0;
            end
            if (finish) begin
                last_grant_reg <= owner_reg;
            end
        end
    end

    // Completion and consumption never collide: a completing port's slot was empty.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_slot
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    resp_valid_reg[gi]  <= 1'b0;
                    resp_result_reg[gi] <= 32'd0;
                    resp_zero_reg[gi]   <= 1'b0;
                end else if (finish && (owner_reg == gi[0])) begin
                    resp_valid_reg[gi]  <= 1'b1;
                    resp_result_reg[gi] <= alu_result;
                    resp_zero_reg[gi]   <= alu_zero;
                end else if (resp_valid_reg[gi] && resp_ready_vec[gi]) begin
                    resp_valid_reg[gi]  <= 1'b0;
                end
            end
        end
    endgenerate

    assign resp_valid_0  = resp_valid_reg[0];
    assign resp_valid_1  = resp_valid_reg[1];
    assign resp_result_0 = resp_result_reg[0];
    assign resp_result_1 = resp_result_reg[1];
    assign resp_zero_0   = resp_zero_reg[0];
    assign resp_zero_1   = resp_zero_reg[1];

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Shares the single combinational ALU between two requesters, for example the integer datapath and a branch/address helper, using a round-robin valid/ready handshake. Each accepted request is captured into operand registers and driven onto the ALU for exactly one cycle. The ALU result and zero flag are registered into a per-requester response slot. The block owns the ALU's A, B and 4-bit control inputs. The ALU itself stays outside the block, instantiated alongside it.

## Interface
- No parameters; data width is fixed at 32 bits and control width at 4 bits.
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- req_valid_0 / req_valid_1  in  1  request present on port 0 / 1.
- req_ready_0 / req_ready_1  out  1  grant; a request is accepted on a cycle with valid && ready.
- req_a_0 / req_a_1  in  32  operand A.
- req_b_0 / req_b_1  in  32  operand B.
- req_ctrl_0 / req_ctrl_1  in  4  ALU control code: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB.
- resp_valid_0 / resp_valid_1  out  1  response held in the slot.
- resp_ready_0 / resp_ready_1  in  1  requester consumes the response.
- resp_result_0 / resp_result_1  out  32  registered ALU result.
- resp_zero_0 / resp_zero_1  out  1  registered ALU zero flag.
- alu_a, alu_b  out  32  operands to the ALU.
- alu_ctrl  out  4  control code to the ALU.
- alu_result  in  32  ALU result, combinational from alu_a / alu_b / alu_ctrl.
- alu_zero  in  1  ALU zero flag.
- busy  out  1  high while in EXEC.

## Operation
- **State machine:** two states, IDLE and EXEC. Reset enters IDLE.
- **Eligibility:** port i is eligible when req_valid_i = 1 and resp_valid_i = 0. Each port has at most one outstanding operation.
- **IDLE, grant selection:**
  - Exactly one eligible port: that port is granted.
  - Both eligible: the port not recorded in last_grant wins.
  - req_ready_i is combinational and asserted only for the granted port, only in IDLE.
- **IDLE, on handshake:**
  - Latch the port's A, B and ctrl into op_a, op_b, op_ctrl.
  - Latch the port index into owner.
  - Go to EXEC.
- **EXEC:**
  - alu_a = op_a, alu_b = op_b, alu_ctrl = op_ctrl.
  - No req_ready is asserted.
  - At the clock edge: resp_result_owner ← alu_result, resp_zero_owner ← alu_zero, resp_valid_owner ← 1, last_grant ← owner, return to IDLE.
- **Outside EXEC:** alu_a = 0, alu_b = 0, alu_ctrl = 4'b1111. This is a non-op code, so the ALU outputs 0 and zero 0.
- **Response slot:**
  - resp_valid_i clears on a cycle with resp_valid_i && resp_ready_i.
  - resp_result_i and resp_zero_i hold their values until the slot is overwritten by that port's next operation.
- **Control codes:** passed through unchecked. For an unsupported code the response carries whatever the ALU returns (with the current ALU: result 0, zero 0).
- **Arithmetic:** none is performed here; results are 32 bits, wrap-around is the ALU's own, and there is no carry.

## Timing
- **Reset values:** state IDLE, last_grant = 1 (so port 0 wins first), owner = 0, op_a / op_b / op_ctrl = 0, all resp_valid = 0, all resp_result = 0, all resp_zero = 0, busy = 0, req_ready = 0 unless granted combinationally.
- **Latency:**
  - Handshake at edge N.
  - ALU driven during cycle N+1.
  - resp_valid visible after edge N+1, i.e. one cycle after acceptance.
- **Throughput:** at most one operation per 2 cycles.
- **Response consumed in the completion cycle:** if resp_ready_i is high in the same cycle the port's EXEC completes, it has no effect. The slot was empty, so the new response is set and stays set.
- **Consume and re-request in the same cycle:** a port whose response is consumed on cycle C becomes eligible on cycle C+1, not on C.
- **Reset mid-EXEC:** the operation is dropped, no response is produced, and the FSM returns to IDLE immediately (asynchronous).
- **Request withdrawal:** req_valid dropping while not granted has no effect. Operands are sampled only at the handshake.

## Test plan
- Port 0 requests ADD, A = 5, B = 7 → req_ready_0 is high the same cycle; one cycle later resp_valid_0 = 1, resp_result_0 = 12, resp_zero_0 = 0.
- Port 1 requests SUB, A = 9, B = 9 → resp_result_1 = 0, resp_zero_1 = 1. Then SUB with A = 3, B = 5 → result 32'hFFFFFFFE, zero 0.
- Both ports valid right after reset (port 0: AND, F0F0 & 0FF0; port 1: OR, 1 | 2) → port 0 is served first with result 00F0, then port 1 with result 3. The alternation repeats while both remain eligible.
- Port 0 holds resp_ready_0 = 0 and keeps req_valid_0 high; port 1 issues repeated requests → only port 1 is granted. After resp_ready_0 pulses, port 0 is granted on the next IDLE cycle.
- Reset asserted during EXEC of port 0 ADD 1 + 1 → resp_valid_0 never rises, busy drops asynchronously, and all outputs are at their reset values.
- Port 0 sends unsupported ctrl 0111, A = 4, B = 4 → resp_valid_0 = 1, result 0, zero 0. While idle, alu_ctrl = 1111 and alu_a = alu_b = 0.
